// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit for the 16-bit core (fetch/decode/exec/mem/wb sequencing).
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt the core instead of executing as NOP.
module ctrl_fsm #(
    parameter int XLEN        = 16,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [2:0]      rd_addr,
    output logic [2:0]      rs1_addr,
    output logic [2:0]      rs2_addr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      alu_op,
    output logic            alu_src_imm,
    input  logic [3:0]      alu_flags,
    output logic            reg_we,
    output logic            wb_sel,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            halted,
    output logic            bus_err,
    output logic            illegal
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam logic [7:0] T_LAST = 8'(BUS_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  flags_q, flags_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;

    logic [3:0] opc;
    logic       is_alu, is_addi, is_ld, is_st, is_br, is_halt, is_ill, taken;
    logic [7:0] cond_vec;

    assign opc      = ir_q[15:12];
    assign is_alu   = opc == 4'h0;
    assign is_addi  = opc == 4'h1;
    assign is_ld    = opc == 4'h2;
    assign is_st    = opc == 4'h3;
    assign is_br    = opc == 4'h4;
    assign is_halt  = opc == 4'hF;
    assign is_ill   = !(is_alu || is_addi || is_ld || is_st || is_br || is_halt);
    // flags_q = {zero, negative, carry, overflow}; indexed by the branch condition field
    assign cond_vec = {1'b0, 1'b1, flags_q[0], flags_q[1], !flags_q[2], flags_q[2], !flags_q[3], flags_q[3]};
    assign taken    = cond_vec[ir_q[11:9]];

    // next-state, instruction latch, flag capture and bus-timeout bookkeeping
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        cnt_d     = 8'd0;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end else if (cnt_q == T_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (is_alu || is_addi) begin
                    flags_d = alu_flags;
                    state_d = WB;
                end else if (is_ld || is_st) begin
                    state_d = MEM;
                end else if (is_halt) begin
                    state_d = HALT;
                end else begin
                    state_d = (is_ill && TRAP) ? HALT : FETCH;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d = is_ld ? WB : FETCH;
                end else if (cnt_q == T_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WB:     state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // state and datapath-control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ir_q      <= 16'h0;
            flags_q   <= 4'h0;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign imem_req    = state_q == FETCH;
    assign dmem_req    = state_q == MEM;
    assign dmem_we     = dmem_req && is_st;
    assign rd_addr     = ir_q[11:9];
    assign rs1_addr    = ir_q[8:6];
    assign rs2_addr    = ir_q[5:3];
    assign imm         = is_br ? {{(XLEN-9){ir_q[8]}}, ir_q[8:0]} : {{(XLEN-6){ir_q[5]}}, ir_q[5:0]};
    assign alu_op      = ((state_q == EXEC || state_q == MEM) && is_alu) ? ir_q[2:0] : 3'd0;
    assign alu_src_imm = (state_q == EXEC || state_q == MEM) && (is_addi || is_ld || is_st);
    assign reg_we      = state_q == WB;
    assign wb_sel      = reg_we && is_ld;
    assign pc_load     = state_q == EXEC && is_br && taken;
    assign pc_inc      = reg_we || (state_q == EXEC && is_br && !taken)
                      || (dmem_req && is_st && dmem_ack) || (state_q == EXEC && is_ill && !TRAP);
    assign halted      = state_q == HALT;
    assign bus_err     = bus_err_q;
    assign illegal     = state_q == EXEC && is_ill;
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed tests for ctrl_fsm with BUS_TIMEOUT=4
module tb_ctrl_fsm;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [2:0]  rd_addr, rs1_addr, rs2_addr, alu_op;
    logic [15:0] imm;
    logic        alu_src_imm, reg_we, wb_sel, pc_inc, pc_load, halted, bus_err, illegal;
    logic [3:0]  alu_flags = 4'h0;
    int          total = 0, bad = 0;

    ctrl_fsm #(.XLEN(16), .BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rd_addr(rd_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .alu_flags(alu_flags), .reg_we(reg_we), .wb_sel(wb_sel),
        .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted), .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the DUT in IDLE with rst released; the next tick enters FETCH
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; alu_flags = 4'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // called in a FETCH cycle; returns in the DECODE cycle
    task automatic fetch(input logic [15:0] instr);
        imem_ack = 1'b1; imem_rdata = instr;
        tick();
        imem_ack = 1'b0; imem_rdata = 16'h0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if ({imem_req, dmem_req, reg_we, pc_inc, pc_load, halted, bus_err, illegal} !== 8'h0) begin
            $display("FAIL reset_strobes got %b exp 0", {imem_req, dmem_req, reg_we, pc_inc, pc_load, halted, bus_err, illegal}); bad++; end
        total++; if ({rd_addr, rs1_addr, rs2_addr, alu_op, imm} !== 28'h0) begin
            $display("FAIL reset_fields got %h exp 0", {rd_addr, rs1_addr, rs2_addr, alu_op, imm}); bad++; end
        tick();
        total++; if (imem_req !== 1'b1) begin $display("FAIL reset_first_fetch got %b exp 1", imem_req); bad++; end
    endtask

    task automatic test_alu_r();
        do_reset(); tick();
        fetch(16'h0A53);
        total++; if ({rd_addr, rs1_addr, rs2_addr} !== {3'd5, 3'd1, 3'd2}) begin
            $display("FAIL alu_fields got %h exp %h", {rd_addr, rs1_addr, rs2_addr}, {3'd5, 3'd1, 3'd2}); bad++; end
        tick();
        total++; if (alu_op !== 3'd3 || alu_src_imm !== 1'b0 || reg_we !== 1'b0) begin
            $display("FAIL alu_exec got op=%0d src=%b we=%b exp op=3 src=0 we=0", alu_op, alu_src_imm, reg_we); bad++; end
        tick();
        total++; if (reg_we !== 1'b1 || pc_inc !== 1'b1 || alu_op !== 3'd0 || rd_addr !== 3'd5 || wb_sel !== 1'b0) begin
            $display("FAIL alu_wb got we=%b inc=%b op=%0d rd=%0d sel=%b exp 1 1 0 5 0", reg_we, pc_inc, alu_op, rd_addr, wb_sel); bad++; end
        tick();
        total++; if (imem_req !== 1'b1 || reg_we !== 1'b0) begin
            $display("FAIL alu_next_fetch got req=%b we=%b exp 1 0", imem_req, reg_we); bad++; end
    endtask

    task automatic test_branch();
        do_reset(); tick();
        fetch(16'h1000);
        tick();
        alu_flags = 4'b1000;
        #1;
        total++; if (alu_src_imm !== 1'b1 || alu_op !== 3'd0) begin
            $display("FAIL addi_exec got src=%b op=%0d exp 1 0", alu_src_imm, alu_op); bad++; end
        tick(); alu_flags = 4'h0; tick();
        fetch(16'h403E);
        total++; if (imm !== 16'h003E) begin $display("FAIL br_imm got %h exp 003e", imm); bad++; end
        tick();
        total++; if (pc_load !== 1'b1 || pc_inc !== 1'b0) begin
            $display("FAIL br_z_taken got load=%b inc=%b exp 1 0", pc_load, pc_inc); bad++; end
        tick();
        fetch(16'h423E); tick();
        total++; if (pc_load !== 1'b0 || pc_inc !== 1'b1) begin
            $display("FAIL br_nz_not_taken got load=%b inc=%b exp 0 1", pc_load, pc_inc); bad++; end
        tick();
        fetch(16'h4FFF);
        total++; if (imm !== 16'hFFFF) begin $display("FAIL br_imm_neg got %h exp ffff", imm); bad++; end
        tick();
        total++; if (pc_load !== 1'b0 || pc_inc !== 1'b1) begin
            $display("FAIL br_never got load=%b inc=%b exp 0 1", pc_load, pc_inc); bad++; end
        tick();
        fetch(16'h4C01); tick();
        total++; if (pc_load !== 1'b1 || pc_inc !== 1'b0) begin
            $display("FAIL br_always got load=%b inc=%b exp 1 0", pc_load, pc_inc); bad++; end
    endtask

    task automatic test_load();
        do_reset(); tick();
        fetch(16'h2A7F);
        total++; if (imm !== 16'hFFFF || rd_addr !== 3'd5) begin
            $display("FAIL ld_decode got imm=%h rd=%0d exp ffff 5", imm, rd_addr); bad++; end
        tick();
        total++; if (alu_src_imm !== 1'b1 || dmem_req !== 1'b0) begin
            $display("FAIL ld_exec got src=%b req=%b exp 1 0", alu_src_imm, dmem_req); bad++; end
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_ack = (i == 3);
            #1;
            total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || alu_src_imm !== 1'b1 || reg_we !== 1'b0) begin
                $display("FAIL ld_mem%0d got req=%b we=%b src=%b rwe=%b exp 1 0 1 0", i, dmem_req, dmem_we, alu_src_imm, reg_we); bad++; end
        end
        tick(); dmem_ack = 1'b0; #1;
        total++; if (wb_sel !== 1'b1 || reg_we !== 1'b1 || dmem_req !== 1'b0 || pc_inc !== 1'b1) begin
            $display("FAIL ld_wb got sel=%b we=%b req=%b inc=%b exp 1 1 0 1", wb_sel, reg_we, dmem_req, pc_inc); bad++; end
        tick();
        total++; if (imem_req !== 1'b1 || bus_err !== 1'b0) begin
            $display("FAIL ld_late_ack got req=%b err=%b exp 1 0", imem_req, bus_err); bad++; end
    endtask

    task automatic test_store();
        do_reset(); tick();
        fetch(16'h3000); tick(); tick();
        dmem_ack = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc_inc !== 1'b1 || reg_we !== 1'b0) begin
            $display("FAIL st_ack got req=%b we=%b inc=%b rwe=%b exp 1 1 1 0", dmem_req, dmem_we, pc_inc, reg_we); bad++; end
        tick(); dmem_ack = 1'b0; #1;
        total++; if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
            $display("FAIL st_next_fetch got ireq=%b dreq=%b exp 1 0", imem_req, dmem_req); bad++; end
    endtask

    task automatic test_timeout();
        do_reset(); tick();
        fetch(16'h3000); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || bus_err !== 1'b0) begin
                $display("FAIL st_wait%0d got req=%b we=%b err=%b exp 1 1 0", i, dmem_req, dmem_we, bus_err); bad++; end
        end
        tick();
        total++; if (bus_err !== 1'b1 || halted !== 1'b1 || dmem_req !== 1'b0) begin
            $display("FAIL st_timeout got err=%b halt=%b req=%b exp 1 1 0", bus_err, halted, dmem_req); bad++; end
        tick(); tick();
        total++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc_inc !== 1'b0) begin
            $display("FAIL halt_sticky got halt=%b req=%b inc=%b exp 1 0 0", halted, imem_req, pc_inc); bad++; end
        do_reset(); tick();
        for (int i = 0; i < 4; i++) tick();
        total++; if (bus_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0) begin
            $display("FAIL fetch_timeout got err=%b halt=%b req=%b exp 1 1 0", bus_err, halted, imem_req); bad++; end
    endtask

    task automatic test_illegal();
        logic trap;
`ifdef ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        do_reset(); tick();
        fetch(16'h7000); tick();
        total++; if (illegal !== 1'b1 || pc_inc !== !trap || pc_load !== 1'b0) begin
            $display("FAIL ill_exec got ill=%b inc=%b load=%b exp 1 %b 0", illegal, pc_inc, pc_load, !trap); bad++; end
        tick();
        total++; if (illegal !== 1'b0 || halted !== trap || imem_req !== !trap) begin
            $display("FAIL ill_after got ill=%b halt=%b req=%b exp 0 %b %b", illegal, halted, imem_req, trap, !trap); bad++; end
    endtask

    task automatic test_halt_op();
        do_reset(); tick();
        fetch(16'hF000); tick();
        total++; if (illegal !== 1'b0 || pc_inc !== 1'b0) begin
            $display("FAIL halt_exec got ill=%b inc=%b exp 0 0", illegal, pc_inc); bad++; end
        tick();
        total++; if (halted !== 1'b1 || bus_err !== 1'b0 || imem_req !== 1'b0) begin
            $display("FAIL halt_state got halt=%b err=%b req=%b exp 1 0 0", halted, bus_err, imem_req); bad++; end
    endtask

    task automatic test_rst_mid();
        do_reset(); tick();
        fetch(16'h2A7F); tick(); tick();
        total++; if (dmem_req !== 1'b1) begin $display("FAIL rst_pre got req=%b exp 1", dmem_req); bad++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if ({imem_req, dmem_req, reg_we, pc_inc, halted, rd_addr, imm} !== 24'h0) begin
            $display("FAIL rst_mid got %h exp 0", {imem_req, dmem_req, reg_we, pc_inc, halted, rd_addr, imm}); bad++; end
        tick();
        total++; if (imem_req !== 1'b1) begin $display("FAIL rst_refetch got %b exp 1", imem_req); bad++; end
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_branch();
        test_load();
        test_store();
        test_timeout();
        test_illegal();
        test_halt_op();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
